// File: rtl/seq_run_chk_pkg.sv
// Shared types and helpers for the multi-channel A/B run checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package seq_run_chk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  // Failure classification carried on fail_code while fail is high.
  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_EARLY = 2'b01;
  localparam logic [1:0] FC_MISS  = 2'b10;
  localparam logic [1:0] FC_BOTH  = 2'b11;

  // Add a popcount to a counter, clamping at max_v instead of wrapping.
  function automatic logic [63:0] sat_add_pop(input logic [63:0] cnt,
                                              input logic [63:0] max_v,
                                              input logic [63:0] pop);
    logic [63:0] res;
    if ((max_v - cnt) < pop) res = max_v;
    else                     res = cnt + pop;
    return res;
  endfunction

endpackage

// File: rtl/seq_run_chk_ch.sv
// One checker channel: A-run FSM, run counter and B violation flags.
// Latency: pass/fail/abort registered, one cycle after the deciding sample.
// Backpressure: none; samples every cycle. SEQ_RUN_CHK_COVER_EN exports rc and abort_nxt.
module seq_run_chk_ch
  import seq_run_chk_pkg::*;
#(
  parameter int A_LEN    = 5,
  parameter int B_OFFSET = 4,
  parameter int REARM    = 0,
  parameter int RC_W     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            a_i,
  input  logic            b_i,
  output logic            pass_o,
  output logic            fail_o,
  output logic            abort_o,
  output logic [1:0]      fail_code_o,
`ifdef SEQ_RUN_CHK_COVER_EN
  output logic [RC_W-1:0] rc_o,
  output logic            abort_nxt_o,
`endif
  output logic            pass_nxt_o,
  output logic            fail_nxt_o
);

  localparam logic [RC_W-1:0] RC_LEN = RC_W'(A_LEN);
  localparam logic [RC_W-1:0] RC_OFF = RC_W'(B_OFFSET);

  state_e          state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d, rc_inc;
  logic            early_q, early_d, early_n;
  logic            miss_q, miss_d, miss_n;
  logic            pass_q, pass_d, fail_q, fail_d, abort_q, abort_d;
  logic [1:0]      code_q, code_d;

  // Next state, run count, sticky violation flags and verdict pulses.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    early_d = early_q;
    miss_d  = miss_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    abort_d = 1'b0;
    code_d  = FC_NONE;
    rc_inc  = rc_q + 1'b1;
    early_n = early_q | (b_i & (rc_inc <= RC_OFF));
    miss_n  = miss_q | (~b_i & (rc_inc > RC_OFF));
    if (clr_i || !en_i) begin
      state_d = IDLE;
      rc_d    = '0;
      early_d = 1'b0;
      miss_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // First A-high sample is window cycle 1, always inside the B-low part.
          if (a_i) begin
            state_d = RUN;
            rc_d    = RC_W'(1);
            early_d = b_i;
            miss_d  = 1'b0;
          end
        end
        RUN: begin
          if (a_i) begin
            rc_d    = rc_inc;
            early_d = early_n;
            miss_d  = miss_n;
            if (rc_inc == RC_LEN) begin
              state_d = (REARM != 0) ? IDLE : WAIT_LOW;
              if (!early_n && !miss_n) begin
                pass_d = 1'b1;
              end else begin
                fail_d = 1'b1;
                code_d = miss_n ? (early_n ? FC_BOTH : FC_MISS) : FC_EARLY;
              end
            end
          end else begin
            abort_d = 1'b1;
            state_d = IDLE;
          end
        end
        WAIT_LOW: begin
          if (!a_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and pulse registers; reset drops any window in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      early_q <= 1'b0;
      miss_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      abort_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      early_q <= early_d;
      miss_q  <= miss_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      abort_q <= abort_d;
      code_q  <= code_d;
    end
  end

  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign abort_o     = abort_q;
  assign fail_code_o = code_q;
  assign pass_nxt_o  = pass_d;
  assign fail_nxt_o  = fail_d;
`ifdef SEQ_RUN_CHK_COVER_EN
  assign rc_o        = rc_q;
  assign abort_nxt_o = abort_d;
`endif

endmodule

// File: rtl/seq_run_chk.sv
// Multi-channel A/B run checker with saturating verdict counters and sticky any_fail.
// Latency: pulses and counter updates appear one cycle after the deciding sample.
// Backpressure: none. Optional SEQ_RUN_CHK_COVER_EN adds abort_cnt and max_rc.
module seq_run_chk
  import seq_run_chk_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int A_LEN    = 5,
  parameter int B_OFFSET = 4,
  parameter int REARM    = 0,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  output logic [NUM_CH-1:0]       pass,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH-1:0]       abort,
  output logic [2*NUM_CH-1:0]     fail_code,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
`ifdef SEQ_RUN_CHK_COVER_EN
  output logic [CNT_W-1:0]        abort_cnt,
  output logic [$clog2(A_LEN+1)-1:0] max_rc,
`endif
  output logic                    any_fail
);

  localparam int          RC_W    = $clog2(A_LEN + 1);
  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (B_OFFSET >= A_LEN || B_OFFSET < 1 || A_LEN < 2 || NUM_CH < 1) begin : g_bad_cfg
    $fatal(1, "seq_run_chk: illegal NUM_CH/A_LEN/B_OFFSET combination");
  end

  logic [NUM_CH-1:0] pass_nxt, fail_nxt;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic              any_fail_q, any_fail_d;
`ifdef SEQ_RUN_CHK_COVER_EN
  logic [NUM_CH-1:0]      abort_nxt;
  logic [NUM_CH*RC_W-1:0] rc_vec;
  logic [CNT_W-1:0]       abort_cnt_q, abort_cnt_d;
  logic [RC_W-1:0]        max_rc_q, max_rc_d;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    seq_run_chk_ch #(
      .A_LEN   (A_LEN),
      .B_OFFSET(B_OFFSET),
      .REARM   (REARM),
      .RC_W    (RC_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en),
      .clr_i      (clr),
      .a_i        (a[i]),
      .b_i        (b[i]),
      .pass_o     (pass[i]),
      .fail_o     (fail[i]),
      .abort_o    (abort[i]),
      .fail_code_o(fail_code[2*i +: 2]),
`ifdef SEQ_RUN_CHK_COVER_EN
      .rc_o       (rc_vec[i*RC_W +: RC_W]),
      .abort_nxt_o(abort_nxt[i]),
`endif
      .pass_nxt_o (pass_nxt[i]),
      .fail_nxt_o (fail_nxt[i])
    );
  end

  // Counters follow the channels' next pulses so both land on the same edge.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    any_fail_d = any_fail_q | (|fail_nxt);
`ifdef SEQ_RUN_CHK_COVER_EN
    abort_cnt_d = abort_cnt_q;
    max_rc_d    = max_rc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rc_vec[i*RC_W +: RC_W] > max_rc_d) max_rc_d = rc_vec[i*RC_W +: RC_W];
    end
`endif
    if (clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      any_fail_d = 1'b0;
`ifdef SEQ_RUN_CHK_COVER_EN
      abort_cnt_d = '0;
      max_rc_d    = '0;
`endif
    end else if (en) begin
      pass_cnt_d = CNT_W'(sat_add_pop(64'(pass_cnt_q), CNT_MAX, 64'($countones(pass_nxt))));
      fail_cnt_d = CNT_W'(sat_add_pop(64'(fail_cnt_q), CNT_MAX, 64'($countones(fail_nxt))));
`ifdef SEQ_RUN_CHK_COVER_EN
      abort_cnt_d = CNT_W'(sat_add_pop(64'(abort_cnt_q), CNT_MAX, 64'($countones(abort_nxt))));
`endif
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      any_fail_q <= 1'b0;
`ifdef SEQ_RUN_CHK_COVER_EN
      abort_cnt_q <= '0;
      max_rc_q    <= '0;
`endif
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      any_fail_q <= any_fail_d;
`ifdef SEQ_RUN_CHK_COVER_EN
      abort_cnt_q <= abort_cnt_d;
      max_rc_q    <= max_rc_d;
`endif
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign any_fail = any_fail_q;
`ifdef SEQ_RUN_CHK_COVER_EN
  assign abort_cnt = abort_cnt_q;
  assign max_rc    = max_rc_q;
`endif

endmodule

// File: doc/seq_run_chk.md
Name: seq_run_chk

Overview:
- Synthesisable, multi-channel checker for the temporal rule "A high for A_LEN consecutive cycles; B low for the first B_OFFSET of those cycles, then high for the rest; A and B both high at the window end".
- Generalises the single-channel assertion check to NUM_CH channels, with configurable lengths, a re-arm mode, failure classification and saturating verdict counters.
- Sits beside the DUT in benches and in emulation builds, where SVA is unavailable.

Parameters:
- NUM_CH, 2: number of independent channels.
- A_LEN, 5: required consecutive A-high cycles per window. Legal range is 2 or more.
- B_OFFSET, 4: number of leading window cycles in which B must be 0. Legal range is 1 to A_LEN-1.
- REARM, 0: 0 means a channel waits for A=0 after a verdict; 1 means a new window starts on the next cycle if A=1.
- CNT_W, 16: width of the verdict counters.

Ports:
- clk, in, 1: sampling clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- en, in, 1: global enable.
- clr, in, 1: synchronous clear of all FSMs, counters and sticky flags.
- a, in, NUM_CH: A signal, one bit per channel.
- b, in, NUM_CH: B signal, one bit per channel.
- pass, out, NUM_CH: one-cycle pulse per channel when a window passes.
- fail, out, NUM_CH: one-cycle pulse per channel when a window fails.
- abort, out, NUM_CH: one-cycle pulse per channel when A drops before A_LEN (vacuous window).
- fail_code, out, 2*NUM_CH: per channel, bits [2i+1:2i]. 01 = early B, 10 = missing B, 11 = both. Valid while fail[i]=1, otherwise 00.
- pass_cnt, out, CNT_W: total passes across all channels, saturating.
- fail_cnt, out, CNT_W: total fails across all channels, saturating.
- any_fail, out, 1: sticky; set by any fail pulse, cleared by rst_n or clr.

Behaviour:
- Reset: all outputs are 0 and all FSMs are in IDLE, applied immediately on rst_n low. Releasing reset mid-window discards that window with no verdict.
- Precedence: clr over en over normal operation. clr=1 forces IDLE, zero counters, any_fail=0 and zero pulses on the next edge. en=0 holds FSMs in IDLE, forces pulses to 0 and holds the counters.
- Per-channel FSM states:
  - IDLE: A=1 moves to RUN with run counter rc=1. Violation flags are set from this first sample.
  - RUN: rc counts sampled A-high cycles, width clog2(A_LEN+1). On each sample with A=1:
    - early_b is set if B=1 and rc is at most B_OFFSET.
    - miss_b is set if B=0 and rc is greater than B_OFFSET.
  - RUN exits:
    - A=0 before rc reaches A_LEN: abort pulse, then IDLE.
    - The sample with rc=A_LEN: verdict. pass if neither flag is set; otherwise fail with fail_code = {miss_b, early_b}.
    - After a verdict: REARM=0 goes to WAIT_LOW; REARM=1 goes to IDLE, so a window restarts on the next sample if A=1.
  - WAIT_LOW: A=0 moves to IDLE. No pulses in this state.
- Latency: verdict or abort pulses are registered. They assert in the cycle after the edge that sampled the deciding value, for exactly one cycle.
- Counters:
  - Each counter increments by the popcount of that cycle's pass or fail vector.
  - It saturates at 2^CNT_W-1 and never wraps.
  - Counter updates are visible in the same cycle as the pulses.
- Channels are fully independent; simultaneous verdicts on several channels are all counted.
- Elaboration checks: B_OFFSET >= A_LEN, A_LEN < 2 or NUM_CH < 1 is a fatal error.

Optional Feature:
- Macro: SEQ_RUN_CHK_COVER_EN.
- Defined: adds output abort_cnt (CNT_W). It counts abort pulses with the same popcount, saturation, clr and en rules as the verdict counters. It also adds output max_rc (clog2(A_LEN+1)), which holds the largest rc reached by any channel since reset or clr.
- Undefined: these ports and their logic do not exist, and all other behaviour is identical.

Decomposition:
- Package seq_run_chk_pkg:
  - State enum {IDLE, RUN, WAIT_LOW}.
  - Fail code localparams FC_NONE, FC_EARLY, FC_MISS, FC_BOTH.
  - Function for a saturating add of a popcount.
- Sub-module seq_run_chk_ch: one channel's FSM, rc and flags. It outputs pass, fail, abort and fail_code.
- The top instantiates NUM_CH channels using generate, plus the counters and any_fail.

Test Plan:
All scenarios use the defaults (NUM_CH=2, A_LEN=5, B_OFFSET=4, REARM=0) unless stated.
1. ch0 A=1 for cycles 1-5, B=1 in cycle 5 only -> pass[0] pulses once after the cycle-5 edge; pass_cnt=1, fail_cnt=0, any_fail=0.
2. ch0 A=1 for cycles 1-5, B=1 in cycles 3-5 -> fail[0] with fail_code[1:0]=01; fail_cnt=1, any_fail=1.
3. ch1 A=1 for cycles 1-5, B=0 throughout -> fail[1] with fail_code[3:2]=10. Adding B=1 in cycle 2 as well -> code 11.
4. ch0 A=1 for cycles 1-3 then A=0 -> abort[0] after the cycle-4 edge; no pass or fail pulse, counters unchanged.
5. Both channels fail on the same edge with CNT_W=2 and fail_cnt=2 beforehand -> fail_cnt saturates at 3. Then clr=1 -> fail_cnt=0 and any_fail=0 next cycle.
6. A held high on ch0 for 12 cycles with B correct in window cycle 5 -> REARM=0 gives one pass (cycle 5); REARM=1 gives passes at cycles 5 and 10. rst_n pulsed low in cycle 3 of a window -> all outputs 0 immediately and no verdict for that window.
